// File: rtl/rr_stream_mux.sv
// rr_stream_mux: CH-way valid/ready stream mux with one registered output
// stage and three grant modes: fixed-select, fixed-priority and round-robin.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   in_data [CH*N]     channel k data at bits [k*N +: N]
//   in_valid/in_ready  per-channel handshake (in_ready is combinational)
//   mode [2]           00 select, 01 priority, 10/11 round-robin
//   sel [SW]           channel used in select mode
//   out_data/out_ch    registered beat and the channel it came from
//   out_valid/out_ready downstream handshake
//   xfer_cnt [16]      wrapping count of completed output transfers
module rr_stream_mux #(
    parameter  int N  = 8,
    parameter  int CH = 8,
    localparam int SW = $clog2(CH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [CH*N-1:0] in_data,
    input  logic [CH-1:0]   in_valid,
    output logic [CH-1:0]   in_ready,
    input  logic [1:0]      mode,
    input  logic [SW-1:0]   sel,
    output logic [N-1:0]    out_data,
    output logic [SW-1:0]   out_ch,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [15:0]     xfer_cnt
);

    logic [N-1:0]  out_data_q, out_data_d;
    logic [SW-1:0] out_ch_q, out_ch_d;
    logic          out_valid_q, out_valid_d;
    logic [15:0]   xfer_cnt_q, xfer_cnt_d;
    logic [SW-1:0] rr_ptr_q, rr_ptr_d;

    logic          gnt_vld;
    logic [SW-1:0] gnt_idx;
    logic          load_en;
    logic          in_xfer;
    int            idx;

    assign load_en = !out_valid_q || out_ready;

    // Loops run from the high end so the lowest index (or the smallest
    // offset from rr_ptr) is the last one written and therefore wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        case (mode)
            2'b00: begin
                for (int k = 0; k < CH; k++) begin
                    if (k == int'(sel) && in_valid[k]) begin
                        gnt_vld = 1'b1;
                        gnt_idx = SW'(k);
                    end
                end
            end
            2'b01: begin
                for (int k = CH - 1; k >= 0; k--) begin
                    if (in_valid[k]) begin
                        gnt_vld = 1'b1;
                        gnt_idx = SW'(k);
                    end
                end
            end
            default: begin
                for (int i = CH - 1; i >= 0; i--) begin
                    idx = int'(rr_ptr_q) + i;
                    if (idx >= CH) begin
                        idx = idx - CH;
                    end
                    if (in_valid[idx]) begin
                        gnt_vld = 1'b1;
                        gnt_idx = SW'(idx);
                    end
                end
            end
        endcase
    end

    // Gating with rst_n keeps the handshake dead while reset is held.
    assign in_xfer  = rst_n && gnt_vld && load_en;
    assign in_ready = in_xfer ? (CH'(1) << gnt_idx) : '0;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        rr_ptr_d    = rr_ptr_q;
        xfer_cnt_d  = xfer_cnt_q;
        if (load_en) begin
            out_valid_d = in_xfer;
        end
        if (in_xfer) begin
            out_data_d = in_data[int'(gnt_idx)*N +: N];
            out_ch_d   = gnt_idx;
            rr_ptr_d   = (int'(gnt_idx) == CH - 1) ? '0 : gnt_idx + SW'(1);
        end
        if (out_valid_q && out_ready) begin
            xfer_cnt_d = xfer_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            rr_ptr_q    <= '0;
            xfer_cnt_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            rr_ptr_q    <= rr_ptr_d;
            xfer_cnt_q  <= xfer_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_rr_stream_mux.sv
// tb_rr_stream_mux: directed stimulus feeding a scoreboard queue, with an
// independent monitor popping and comparing every output handshake.
module tb_rr_stream_mux;

    localparam int N  = 8;
    localparam int CH = 8;
    localparam int SW = 3;

    typedef struct packed {
        logic [SW-1:0] ch;
        logic [N-1:0]  data;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [CH*N-1:0] in_data;
    logic [CH-1:0]   in_valid;
    logic [CH-1:0]   in_ready;
    logic [1:0]      mode;
    logic [SW-1:0]   sel;
    logic [N-1:0]    out_data;
    logic [SW-1:0]   out_ch;
    logic            out_valid;
    logic            out_ready;
    logic [15:0]     xfer_cnt;

    beat_t sb[$];
    int    checks = 0;
    int    errors = 0;
    int    pops   = 0;
    int    seq[CH];

    always #5 clk = ~clk;

    rr_stream_mux #(.N(N), .CH(CH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .xfer_cnt  (xfer_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic set_data(input int k, input logic [N-1:0] v);
        in_data[k*N +: N] = v;
    endtask

    task automatic push(input int c, input logic [N-1:0] d);
        sb.push_back({SW'(c), d});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mon_extra got ch %0d data %0h want none",
                             out_ch, out_data);
                end else begin
                    e = sb.pop_front();
                    pops++;
                    chk("mon_ch", 32'(out_ch), 32'(e.ch));
                    chk("mon_data", 32'(out_data), 32'(e.data));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 8'hFF;
        mode      = 2'b10;
        sel       = '0;
        out_ready = 1'b1;
        in_data   = '0;
        for (int k = 0; k < CH; k++) set_data(k, 8'h10 + N'(k));

        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_ch", 32'(out_ch), 0);
        chk("rst_xfer_cnt", 32'(xfer_cnt), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        #2;
        rst_n    = 1'b1;
        in_valid = '0;
        step();

        // round-robin with every channel valid, back-to-back
        mode     = 2'b10;
        in_valid = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            push(i % CH, 8'h10 + N'(i % CH));
            if (i == 0) begin
                @(negedge clk);
                chk("rr_in_ready", 32'(in_ready), 32'h01);
            end
            step();
        end
        in_valid = '0;
        step();
        chk("rr_xfer_cnt", 32'(xfer_cnt), 9);
        chk("rr_idle_valid", 32'(out_valid), 0);

        // fixed priority picks channel 2 out of 1010_0100
        mode     = 2'b01;
        in_valid = 8'b1010_0100;
        for (int i = 0; i < 3; i++) begin
            push(2, 8'h12);
            if (i == 0) begin
                @(negedge clk);
                chk("pri_in_ready", 32'(in_ready), 32'h04);
            end
            step();
        end
        in_valid = '0;
        step();
        chk("pri_xfer_cnt", 32'(xfer_cnt), 12);

        // fixed select with a three-cycle downstream stall
        mode      = 2'b00;
        sel       = 3'd5;
        set_data(5, 8'hFF);
        in_valid  = 8'h20;
        out_ready = 1'b0;
        push(5, 8'hFF);
        step();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_valid", 32'(out_valid), 1);
            chk("stall_data", 32'(out_data), 32'hFF);
            chk("stall_in_ready", 32'(in_ready), 0);
            step();
        end
        out_ready = 1'b1;
        in_valid  = '0;
        step();
        chk("stall_xfer_cnt", 32'(xfer_cnt), 13);
        chk("stall_drained", 32'(out_valid), 0);
        set_data(5, 8'h15);

        // rr_ptr is now 6: search wraps to 0, then 1, then pointer at 2
        mode     = 2'b10;
        in_valid = 8'b0000_0011;
        push(0, 8'h10);
        @(negedge clk);
        chk("wrap_in_ready", 32'(in_ready), 32'h01);
        step();
        push(1, 8'h11);
        step();
        in_valid = 8'hFF;
        push(2, 8'h12);
        step();
        in_valid = '0;
        step();
        chk("wrap_xfer_cnt", 32'(xfer_cnt), 16);
        chk("hold_out_ch", 32'(out_ch), 2);
        chk("hold_out_data", 32'(out_data), 32'h12);

        // mode 11 behaves as round-robin from rr_ptr=3
        mode     = 2'b11;
        in_valid = 8'hFF;
        push(3, 8'h13);
        step();
        in_valid = '0;
        step();
        chk("m11_xfer_cnt", 32'(xfer_cnt), 17);

        // asynchronous reset while a beat is stalled in the output register
        mode      = 2'b10;
        in_valid  = 8'hFF;
        out_ready = 1'b0;
        push(4, 8'h14);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_data", 32'(out_data), 0);
        chk("arst_ch", 32'(out_ch), 0);
        chk("arst_xfer_cnt", 32'(xfer_cnt), 0);
        chk("arst_in_ready", 32'(in_ready), 0);
        sb.delete();
        @(negedge clk);
        out_ready = 1'b1;
        push(0, 8'h10);
        #2;
        rst_n = 1'b1;
        step();
        in_valid = '0;
        step();
        chk("arst_after_cnt", 32'(xfer_cnt), 1);

        // 65536 transfers: counter wraps, per-channel sequence intact
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        step();
        chk("long_start_cnt", 32'(xfer_cnt), 0);
        pops = 0;
        for (int k = 0; k < CH; k++) seq[k] = 0;
        mode     = 2'b10;
        in_valid = 8'hFF;
        for (int i = 0; i < 65536; i++) begin
            int c;
            c = i % CH;
            set_data(c, seq[c][7:0]);
            push(c, seq[c][7:0]);
            step();
            seq[c]++;
        end
        chk("long_cnt_ffff", 32'(xfer_cnt), 32'hFFFF);
        in_valid = '0;
        step();
        chk("long_cnt_wrap", 32'(xfer_cnt), 0);
        chk("long_pops", 32'(pops), 65536);
        chk("long_sb_empty", 32'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
